// File: rtl/rd_req_sched.sv
// rd_req_sched: issues sequential cache-line read requests for a job,
// throttled by channel almost-full flags and an in-flight line credit
// limit, and completes once every issued line is retired by write responses.
module rd_req_sched #(
    parameter int unsigned ADDR_W       = 42,
    parameter int unsigned MAX_INFLIGHT = 62
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [31:0]       num_lines,
    input  logic              c0_alm_full,
    input  logic              c1_alm_full,
    input  logic              wr_rsp_valid,
    input  logic [2:0]        wr_rsp_lines,
    output logic              rd_req_valid,
    output logic [ADDR_W-1:0] rd_req_addr,
    output logic [15:0]       rd_req_mdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       issued_cnt,
    output logic [31:0]       retired_cnt,
    output logic [7:0]        inflight
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    localparam logic [8:0] MAX_IF = 9'(MAX_INFLIGHT);

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       num_q;

    logic              eligible;
    logic              last_issue;
    logic              rsp_take;
    logic [2:0]        rsp_lines;
    logic [8:0]        inflight_sum;
    logic [7:0]        inflight_nxt;

    // Issue eligibility, response decode and net in-flight update (clamped at zero)
    always_comb begin
        eligible = (state == ISSUE) && !abort && !c0_alm_full && !c1_alm_full &&
                   ({1'b0, inflight} < MAX_IF) && (issued_cnt < num_q);
        last_issue = eligible && ((issued_cnt + 32'd1) == num_q);

        rsp_take = wr_rsp_valid && ((state == ISSUE) || (state == DRAIN));
        case (wr_rsp_lines)
            3'd1, 3'd2, 3'd4: rsp_lines = rsp_take ? wr_rsp_lines : 3'd0;
            default:          rsp_lines = 3'd0;
        endcase

        inflight_sum = {1'b0, inflight} + {8'b0, eligible};
        if (inflight_sum < {6'b0, rsp_lines}) begin
            inflight_nxt = '0;
        end else begin
            inflight_nxt = 8'(inflight_sum - {6'b0, rsp_lines});
        end
    end

    // Job state machine with registered request, completion and counter outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            base_q       <= '0;
            num_q        <= '0;
            rd_req_valid <= 1'b0;
            rd_req_addr  <= '0;
            rd_req_mdata <= '0;
            done         <= 1'b0;
            issued_cnt   <= '0;
            retired_cnt  <= '0;
            inflight     <= '0;
        end else begin
            rd_req_valid <= 1'b0;
            done         <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        base_q      <= src_base;
                        num_q       <= num_lines;
                        issued_cnt  <= '0;
                        retired_cnt <= '0;
                        inflight    <= '0;
                        state       <= (num_lines == 32'd0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (eligible) begin
                        rd_req_valid <= 1'b1;
                        rd_req_addr  <= base_q + ADDR_W'(issued_cnt);
                        rd_req_mdata <= issued_cnt[15:0];
                        issued_cnt   <= issued_cnt + 32'd1;
                    end
                    // Leave on the final issue itself so no idle ISSUE cycle follows it
                    if (abort || last_issue) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (retired_cnt >= issued_cnt) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (rsp_take) begin
                retired_cnt <= retired_cnt + {29'b0, rsp_lines};
            end
            if ((state == ISSUE) || (state == DRAIN)) begin
                inflight <= inflight_nxt;
            end
        end
    end

    // Busy is a direct decode of the state register
    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_rd_req_sched.sv
// tb_rd_req_sched: directed stimulus with a per-cycle reference model and
// hand-computed literal checks for rd_req_sched.
module tb_rd_req_sched;

    localparam int AW   = 42;
    localparam int MAXI = 62;

    logic          clk = 1'b0;
    logic          reset, start, abort;
    logic [AW-1:0] src_base;
    logic [31:0]   num_lines;
    logic          c0_alm_full, c1_alm_full;
    logic          wr_rsp_valid;
    logic [2:0]    wr_rsp_lines;
    logic          rd_req_valid;
    logic [AW-1:0] rd_req_addr;
    logic [15:0]   rd_req_mdata;
    logic          busy, done;
    logic [31:0]   issued_cnt, retired_cnt;
    logic [7:0]    inflight;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    rd_req_sched #(.ADDR_W(AW), .MAX_INFLIGHT(MAXI)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .src_base(src_base), .num_lines(num_lines),
        .c0_alm_full(c0_alm_full), .c1_alm_full(c1_alm_full),
        .wr_rsp_valid(wr_rsp_valid), .wr_rsp_lines(wr_rsp_lines),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
        .rd_req_mdata(rd_req_mdata), .busy(busy), .done(done),
        .issued_cnt(issued_cnt), .retired_cnt(retired_cnt), .inflight(inflight)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Write-response source: automatic 1-line reply 5 cycles after each request, or manual
    logic       auto_rsp = 1'b0;
    logic       man_v    = 1'b0;
    logic [2:0] man_l    = 3'd0;
    logic [7:0] sh       = '0;
    always @(posedge clk) begin
        #2;
        sh = {sh[6:0], rd_req_valid === 1'b1};
        if (auto_rsp) begin
            wr_rsp_valid = sh[4];
            wr_rsp_lines = 3'd1;
        end else begin
            wr_rsp_valid = man_v;
            wr_rsp_lines = man_l;
        end
    end

    // Request / done monitor
    typedef struct { logic [AW-1:0] addr; logic [15:0] md; int c; } req_t;
    req_t          req_q[$];
    int            req_n   = 0;
    int            done_n  = 0;
    int            done_c  = 0;
    logic [AW-1:0] a1;
    logic [15:0]   md65535, md65536;
    always @(posedge clk) begin
        #2;
        if (rd_req_valid === 1'b1) begin
            if (req_q.size() < 200) req_q.push_back('{rd_req_addr, rd_req_mdata, cyc});
            if (req_n == 1) a1 = rd_req_addr;
            if (req_n == 65535) md65535 = rd_req_mdata;
            if (req_n == 65536) md65536 = rd_req_mdata;
            req_n++;
        end
        if (done === 1'b1) begin
            done_n++;
            done_c = cyc;
        end
    end

    // Reference model: job phases 0=idle 1=issuing 2=draining 3=finishing
    int            m_ph, m_inf;
    int unsigned   m_iss, m_ret, m_num;
    logic [AW-1:0] m_base, m_addr;
    logic [15:0]   m_md;
    logic          m_v, m_done;
    bit            m_ok = 0;
    always @(posedge clk) begin
        int r;
        bit go;
        if (reset) begin
            m_ph = 0; m_iss = 0; m_ret = 0; m_inf = 0;
            m_v = 0; m_done = 0; m_addr = '0; m_md = '0; m_ok = 1;
        end else begin
            r = 0;
            if (wr_rsp_valid && (m_ph == 1 || m_ph == 2) &&
                (wr_rsp_lines == 1 || wr_rsp_lines == 2 || wr_rsp_lines == 4))
                r = int'(wr_rsp_lines);
            m_v = 0;
            m_done = 0;
            case (m_ph)
                0: if (start) begin
                    m_iss = 0; m_ret = 0; m_inf = 0;
                    m_base = src_base; m_num = num_lines;
                    m_ph = (num_lines == 0) ? 3 : 1;
                end
                1: begin
                    go = !abort && !c0_alm_full && !c1_alm_full && m_inf < MAXI && m_iss < m_num;
                    if (go) begin
                        m_v = 1;
                        m_addr = m_base + AW'(m_iss);
                        m_md = 16'(m_iss);
                        m_iss++;
                        m_inf++;
                    end
                    if (abort || m_iss == m_num) m_ph = 2;
                end
                2: if (m_ret >= m_iss) m_ph = 3;
                default: begin m_done = 1; m_ph = 0; end
            endcase
            m_ret += r;
            m_inf = (m_inf > r) ? m_inf - r : 0;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (m_ok) begin
            total++;
            if ({rd_req_valid, rd_req_addr, rd_req_mdata, busy, done, issued_cnt, retired_cnt, inflight} !==
                {m_v, m_addr, m_md, m_ph != 0, m_done, 32'(m_iss), 32'(m_ret), 8'(m_inf)}) begin
                bad++;
                $display("FAIL cycle %0d outputs: got v=%0b a=%0h md=%0h busy=%0b done=%0b iss=%0d ret=%0d inf=%0d want v=%0b a=%0h md=%0h busy=%0b done=%0b iss=%0d ret=%0d inf=%0d",
                         cyc, rd_req_valid, rd_req_addr, rd_req_mdata, busy, done, issued_cnt, retired_cnt, inflight,
                         m_v, m_addr, m_md, m_ph != 0, m_done, m_iss, m_ret, m_inf);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic start_job(input logic [AW-1:0] b, input logic [31:0] n);
        @(negedge clk);
        src_base = b; num_lines = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
    endtask

    task automatic send_rsp(input logic [2:0] l);
        @(negedge clk); man_v = 1'b1; man_l = l;
        @(negedge clk); man_v = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n0;
        int k;
        n0 = done_n;
        k = 0;
        while (done_n == n0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (done_n == n0) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done within %0d cycles want done", lim);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_issued(input int n, input int lim);
        int k;
        k = 0;
        while (issued_cnt != 32'(n) && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (issued_cnt != 32'(n)) begin
            total++; bad++;
            $display("FAIL issue_timeout: got %0d issued want %0d", issued_cnt, n);
        end
    endtask

    task automatic clear_mon();
        req_q.delete();
        req_n = 0;
        done_n = 0;
    endtask

    initial begin
        int p, inwin, at_p10, at_pm1, d0;
        reset = 1'b1; start = 1'b0; abort = 1'b0; src_base = '0; num_lines = '0;
        c0_alm_full = 1'b0; c1_alm_full = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_valid", 64'(rd_req_valid), 64'd0);
        chk("reset_issued", 64'(issued_cnt), 64'd0);
        chk("reset_addr", 64'(rd_req_addr), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic 4-line job with 1-line replies
        clear_mon();
        auto_rsp = 1'b1;
        start_job(AW'(42'h1000), 32'd4);
        wait_done(100);
        chk("basic_count", 64'(req_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < req_q.size(); i++) begin
            chk("basic_addr", 64'(req_q[i].addr), 64'h1000 + 64'(i));
            chk("basic_mdata", 64'(req_q[i].md), 64'(i));
        end
        chk("basic_done_pulses", 64'(done_n), 64'd1);
        chk("basic_issued", 64'(issued_cnt), 64'd4);
        chk("basic_retired", 64'(retired_cnt), 64'd4);

        // Zero-length job
        clear_mon();
        @(negedge clk);
        src_base = '0; num_lines = 32'd0; start = 1'b1;
        p = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("zero_done_pulses", 64'(done_n), 64'd1);
        chk("zero_done_cycle", 64'(done_c), 64'(p + 1));
        chk("zero_requests", 64'(req_n), 64'd0);

        // Credit limit with responses withheld
        clear_mon();
        auto_rsp = 1'b0;
        start_job('0, 32'd100);
        repeat (80) @(negedge clk);
        chk("credit_requests", 64'(req_n), 64'd62);
        chk("credit_issued", 64'(issued_cnt), 64'd62);
        chk("credit_inflight", 64'(inflight), 64'd62);
        send_rsp(3'd4);
        repeat (20) @(negedge clk);
        chk("credit_more_requests", 64'(req_n), 64'd66);
        chk("credit_inflight_refill", 64'(inflight), 64'd62);
        send_rsp(3'd3);
        repeat (2) @(negedge clk);
        chk("invalid_lines_ignored", 64'(retired_cnt), 64'd4);
        pulse_abort();
        for (int i = 0; i < 16; i++) send_rsp(3'd4);
        wait_done(50);
        chk("credit_retired", 64'(retired_cnt), 64'd68);
        chk("credit_inflight_clamp", 64'(inflight), 64'd0);
        chk("credit_issued_final", 64'(issued_cnt), 64'd66);

        // Backpressure on the write channel
        clear_mon();
        auto_rsp = 1'b1;
        start_job(AW'(42'h5000), 32'd40);
        repeat (5) @(negedge clk);
        p = cyc + 1;
        c1_alm_full = 1'b1;
        repeat (10) @(negedge clk);
        c1_alm_full = 1'b0;
        wait_done(200);
        inwin = 0; at_p10 = 0; at_pm1 = 0;
        foreach (req_q[i]) begin
            if (req_q[i].c >= p && req_q[i].c <= p + 9) inwin++;
            if (req_q[i].c == p + 10) at_p10++;
            if (req_q[i].c == p - 1) at_pm1++;
        end
        chk("bp_window_quiet", 64'(inwin), 64'd0);
        chk("bp_resume", 64'(at_p10), 64'd1);
        chk("bp_before", 64'(at_pm1), 64'd1);
        chk("bp_total", 64'(req_n), 64'd40);

        // Abort after 10 issues
        clear_mon();
        start_job('0, 32'd50);
        wait_issued(10, 100);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(100);
        chk("abort_requests", 64'(req_n), 64'd10);
        chk("abort_issued", 64'(issued_cnt), 64'd10);
        chk("abort_retired", 64'(retired_cnt), 64'd10);
        chk("abort_done_pulses", 64'(done_n), 64'd1);

        // Start while busy ignored, then reset mid-drain
        clear_mon();
        auto_rsp = 1'b0;
        start_job(AW'(42'h7000), 32'd3);
        repeat (6) @(negedge clk);
        start_job(AW'(42'h9000), 32'd20);
        repeat (6) @(negedge clk);
        chk("busy_start_ignored", 64'(issued_cnt), 64'd3);
        chk("busy_still", 64'(busy), 64'd1);
        d0 = done_n;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_issued", 64'(issued_cnt), 64'd0);
        clear_mon();
        auto_rsp = 1'b1;
        reset = 1'b0;
        src_base = AW'(42'h2000); num_lines = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100);
        chk("rst_no_done", 64'(d0), 64'd0);
        chk("post_rst_count", 64'(req_q.size()), 64'd2);
        if (req_q.size() == 2) begin
            chk("post_rst_addr0", 64'(req_q[0].addr), 64'h2000);
            chk("post_rst_addr1", 64'(req_q[1].addr), 64'h2001);
        end

        // Address and tag wrap
        clear_mon();
        start_job('1, 32'd70000);
        wait_issued(65540, 70000);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(100);
        chk("wrap_addr0", 64'(req_q[0].addr), 64'h3FF_FFFF_FFFF);
        chk("wrap_addr1", 64'(a1), 64'd0);
        chk("wrap_md65535", 64'(md65535), 64'hFFFF);
        chk("wrap_md65536", 64'(md65536), 64'd0);
        chk("wrap_issued", 64'(issued_cnt), 64'd65540);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rd_req_sched.md
RD_REQ_SCHED -- requirements
Module: rd_req_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 42, cache-line address width.
REQ-002 SHALL have parameter MAX_INFLIGHT, default 62, maximum number of read lines issued but not yet retired by a write response.
REQ-003 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  single-cycle job start pulse.
REQ-006 SHALL have port abort  in  1  single-cycle request to stop issuing.
REQ-007 SHALL have port src_base  in  ADDR_W  first source line address, sampled on accepted start.
REQ-008 SHALL have port num_lines  in  32  job length in lines, sampled on accepted start.
REQ-009 SHALL have port c0_alm_full  in  1  read request channel almost full.
REQ-010 SHALL have port c1_alm_full  in  1  write request channel almost full.
REQ-011 SHALL have port wr_rsp_valid  in  1  write response strobe.
REQ-012 SHALL have port wr_rsp_lines  in  3  lines retired by the response (1, 2 or 4).
REQ-013 SHALL have port rd_req_valid  out  1  read request strobe.
REQ-014 SHALL have port rd_req_addr  out  ADDR_W  read line address.
REQ-015 SHALL have port rd_req_mdata  out  16  request tag.
REQ-016 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-017 SHALL have port done  out  1  single-cycle job completion pulse.
REQ-018 SHALL have port issued_cnt  out  32  read requests issued in the current job.
REQ-019 SHALL have port retired_cnt  out  32  lines retired in the current job.
REQ-020 SHALL have port inflight  out  8  issued lines not yet retired.

Function
REQ-021 SHALL implement the states IDLE, ISSUE, DRAIN and DONE.
REQ-022 SHALL, in IDLE on start with num_lines != 0, latch src_base and num_lines, clear issued_cnt, retired_cnt and inflight, and enter ISSUE.
REQ-023 SHALL, in IDLE on start with num_lines == 0, enter DONE directly with all counters cleared.
REQ-024 SHALL ignore start in any state other than IDLE.
REQ-025 SHALL, in ISSUE, treat a cycle as eligible iff !c0_alm_full && !c1_alm_full && inflight < MAX_INFLIGHT && issued_cnt < latched num_lines, with all terms taken from registered values.
REQ-026 SHALL, on each eligible cycle, drive rd_req_valid=1 on the next cycle with rd_req_addr = base + issued_cnt (modulo 2^ADDR_W) and rd_req_mdata = issued_cnt[15:0].
REQ-027 SHALL increment issued_cnt and inflight at the same edge that sets rd_req_valid; the next eligibility evaluation SHALL therefore see the updated values.
REQ-028 SHALL hold rd_req_valid at 0 on every non-eligible cycle, and SHALL leave addr and mdata unchanged when valid is 0.
REQ-029 SHALL let rd_req_mdata wrap from 0xFFFF to 0x0000 with no side effect.
REQ-030 SHALL enter DRAIN when issued_cnt reaches num_lines, or on abort in ISSUE; abort SHALL block any further issue from that cycle on.
REQ-031 SHALL, in DRAIN, enter DONE once retired_cnt >= issued_cnt.
REQ-032 SHALL, in DONE, assert done for one cycle and then return to IDLE.
REQ-033 SHALL ignore abort outside ISSUE.
REQ-034 SHALL, on wr_rsp_valid in ISSUE or DRAIN, add wr_rsp_lines to retired_cnt and subtract it from inflight.
REQ-035 SHALL apply the net change to inflight when an issue and a response occur in the same cycle.
REQ-036 SHALL clamp inflight at 0 if a decrement would underflow, while retired_cnt still adds the full amount.
REQ-037 SHALL treat wr_rsp_lines values 0, 3, 5, 6 and 7 as 0.
REQ-038 SHALL ignore wr_rsp_valid in IDLE and DONE.

Reset
REQ-039 SHALL, while reset is high, force state=IDLE and drive rd_req_valid=0, done=0, busy=0, issued_cnt=0, retired_cnt=0, inflight=0, rd_req_addr=0 and rd_req_mdata=0.
REQ-040 SHALL let reset asserted mid-job abandon the job immediately, produce no done pulse, and accept start on the first cycle after reset deasserts.

Verification
REQ-041 Basic job: base=0x1000, num_lines=4, no almFull, each request answered by a 1-line response 5 cycles later -> addresses 0x1000..0x1003, mdata 0..3, exactly one done pulse, issued_cnt=retired_cnt=4.
REQ-042 Credit limit: num_lines=100, responses withheld -> exactly 62 requests issued and inflight=62; releasing one 4-line response -> exactly 4 further requests.
REQ-043 Backpressure: c1_alm_full held for 10 cycles mid-job -> no rd_req_valid during those cycles plus the one-cycle pipeline delay, and issuing resumes afterwards.
REQ-044 Abort: abort after 10 issues with num_lines=50 -> no further requests, done pulse after 10 lines retired, issued_cnt=10.
REQ-045 Wrap: base=0x3FF_FFFF_FFFF (all ones for ADDR_W=42), num_lines=70000 -> second address is 0, and the mdata for index 65536 is 0x0000.
REQ-046 Edges: start with num_lines=0 -> done pulse 2 cycles after start with no requests; start while busy -> ignored; reset mid-DRAIN -> IDLE with no done pulse.
